// File: rtl/dual_issue_queue.sv
// ============================================================================
//  Module      : dual_issue_queue
//  Description : DEPTH-entry circular instruction queue between I-Cache fetch
//                and decode. Accepts one or two instructions per cycle and
//                issues up to two per cycle in program order. The younger
//                head entry issues alongside the oldest only when it has no
//                register or control hazard against it.
//  Ports       : clk, rst (async, active-high), flush (sync redirect clear)
//                in_valid/in_ready, in_instr0/in_instr1/in_instr1_valid
//                out_instr0/out_instr1, out_valid0/out_valid1, out_ready
//                split, count
//                ISSUE_STATS_EN (macro) adds dual_cnt, single_cnt, split_cnt
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dual_issue_queue #(
    parameter int DEPTH   = 8,
    parameter int INSTR_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [INSTR_W-1:0]         in_instr0,
    input  logic [INSTR_W-1:0]         in_instr1,
    input  logic                       in_instr1_valid,
    output logic                       in_ready,
    output logic [INSTR_W-1:0]         out_instr0,
    output logic [INSTR_W-1:0]         out_instr1,
    output logic                       out_valid0,
    output logic                       out_valid1,
    input  logic                       out_ready,
    output logic                       split,
`ifdef ISSUE_STATS_EN
    output logic [31:0]                dual_cnt,
    output logic [31:0]                single_cnt,
    output logic [31:0]                split_cnt,
`endif
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH+1);

    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;

    // Queue state
    logic [INSTR_W-1:0] r_mem_q [DEPTH];
    logic [c_PTR_W-1:0] r_head_q, w_head_d;
    logic [c_PTR_W-1:0] r_tail_q, w_tail_d;
    logic [c_CNT_W-1:0] r_count_q, w_count_d;

    logic [c_PTR_W-1:0] w_head_p1;
    logic [c_PTR_W-1:0] w_tail_p1;
    logic               w_push;
    logic               w_pop;
    logic [1:0]         w_push_n;
    logic [1:0]         w_pop_n;
    logic               w_wr0_en;
    logic               w_wr1_en;
    logic               w_two_avail;

    // Hazard detection fields (fixed RV32 positions, no format decoding)
    logic [4:0] w_rd0;
    logic [4:0] w_rd1;
    logic [4:0] w_rs1_1;
    logic [4:0] w_rs2_1;
    logic [6:0] w_opc0;
    logic       w_raw;
    logic       w_waw;
    logic       w_ctrl;

    // Power-of-two depth makes pointer wrap a natural overflow.
    assign w_head_p1 = r_head_q + c_PTR_W'(1);
    assign w_tail_p1 = r_tail_q + c_PTR_W'(1);

    assign out_instr0 = r_mem_q[r_head_q];
    assign out_instr1 = r_mem_q[w_head_p1];

    assign w_rd0   = out_instr0[11:7];
    assign w_opc0  = out_instr0[6:0];
    assign w_rd1   = out_instr1[11:7];
    assign w_rs1_1 = out_instr1[19:15];
    assign w_rs2_1 = out_instr1[24:20];

    assign w_raw  = (w_rd0 != 5'd0) && ((w_rd0 == w_rs1_1) || (w_rd0 == w_rs2_1));
    assign w_waw  = (w_rd0 != 5'd0) && (w_rd0 == w_rd1);
    assign w_ctrl = (w_opc0 == c_OPC_BRANCH) || (w_opc0 == c_OPC_JAL) ||
                    (w_opc0 == c_OPC_JALR);

    assign w_two_avail = (r_count_q >= c_CNT_W'(2));

    assign out_valid0 = (r_count_q != '0);
    assign out_valid1 = w_two_avail && !w_raw && !w_waw && !w_ctrl;
    assign split      = out_valid0 && w_two_avail && !out_valid1;

    // Ready needs room for a full pair regardless of how many are pushed,
    // and deliberately ignores a same-cycle pop.
    assign in_ready = (r_count_q <= c_CNT_W'(DEPTH - 2));
    assign count    = r_count_q;

    assign w_push   = in_valid && in_ready;
    assign w_pop    = out_ready && out_valid0;
    assign w_push_n = w_push ? (in_instr1_valid ? 2'd2 : 2'd1) : 2'd0;
    assign w_pop_n  = w_pop  ? (out_valid1      ? 2'd2 : 2'd1) : 2'd0;

    // A flush discards the same-cycle push, so no write either.
    assign w_wr0_en = w_push && !flush;
    assign w_wr1_en = w_push && in_instr1_valid && !flush;

    always_comb begin
        w_head_d  = r_head_q + c_PTR_W'(w_pop_n);
        w_tail_d  = r_tail_q + c_PTR_W'(w_push_n);
        w_count_d = r_count_q + c_CNT_W'(w_push_n) - c_CNT_W'(w_pop_n);
        if (flush) begin
            w_head_d  = '0;
            w_tail_d  = '0;
            w_count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head_q  <= '0;
            r_tail_q  <= '0;
            r_count_q <= '0;
        end else begin
            r_head_q  <= w_head_d;
            r_tail_q  <= w_tail_d;
            r_count_q <= w_count_d;
        end
    end

    // Storage carries no reset: contents are only observed while counted.
    always_ff @(posedge clk) begin
        if (w_wr0_en) begin
            r_mem_q[r_tail_q] <= in_instr0;
        end
        if (w_wr1_en) begin
            r_mem_q[w_tail_p1] <= in_instr1;
        end
    end

`ifdef ISSUE_STATS_EN
    logic [31:0] r_dual_cnt_q,   w_dual_cnt_d;
    logic [31:0] r_single_cnt_q, w_single_cnt_d;
    logic [31:0] r_split_cnt_q,  w_split_cnt_d;

    always_comb begin
        w_dual_cnt_d   = r_dual_cnt_q;
        w_single_cnt_d = r_single_cnt_q;
        w_split_cnt_d  = r_split_cnt_q;
        if (w_pop) begin
            if (out_valid1) begin
                w_dual_cnt_d = r_dual_cnt_q + 32'd1;
            end else begin
                w_single_cnt_d = r_single_cnt_q + 32'd1;
            end
            if (split) begin
                w_split_cnt_d = r_split_cnt_q + 32'd1;
            end
        end
    end

    // Statistics survive a redirect flush; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dual_cnt_q   <= '0;
            r_single_cnt_q <= '0;
            r_split_cnt_q  <= '0;
        end else begin
            r_dual_cnt_q   <= w_dual_cnt_d;
            r_single_cnt_q <= w_single_cnt_d;
            r_split_cnt_q  <= w_split_cnt_d;
        end
    end

    assign dual_cnt   = r_dual_cnt_q;
    assign single_cnt = r_single_cnt_q;
    assign split_cnt  = r_split_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dual_issue_queue.sv
// ============================================================================
//  Module      : tb_dual_issue_queue
//  Description : Directed self-checking bench for dual_issue_queue (DEPTH=8).
//                Inputs change and outputs are sampled 1 ns after each
//                rising clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dual_issue_queue;

    localparam int DEPTH   = 8;
    localparam int INSTR_W = 32;

    localparam logic [31:0] c_ADD_A  = 32'h002081B3; // add x3,x1,x2
    localparam logic [31:0] c_ADD_B  = 32'h00208333; // add x6,x1,x2
    localparam logic [31:0] c_ADD_RW = 32'h004182B3; // add x5,x3,x4
    localparam logic [31:0] c_BEQ    = 32'h00208463; // beq x1,x2
    localparam logic [31:0] c_NOP    = 32'h00000013; // addi x0,x0,0
    localparam logic [31:0] c_ADD_X0 = 32'h004002B3; // add x5,x0,x4

    logic                clk;
    logic                rst;
    logic                flush;
    logic                in_valid;
    logic [INSTR_W-1:0]  in_instr0;
    logic [INSTR_W-1:0]  in_instr1;
    logic                in_instr1_valid;
    logic                in_ready;
    logic [INSTR_W-1:0]  out_instr0;
    logic [INSTR_W-1:0]  out_instr1;
    logic                out_valid0;
    logic                out_valid1;
    logic                out_ready;
    logic                split;
    logic [3:0]          count;
`ifdef ISSUE_STATS_EN
    logic [31:0]         dual_cnt;
    logic [31:0]         single_cnt;
    logic [31:0]         split_cnt;
`endif

    int errors = 0;
    int checks = 0;

    dual_issue_queue #(
        .DEPTH   (DEPTH),
        .INSTR_W (INSTR_W)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_instr0       (in_instr0),
        .in_instr1       (in_instr1),
        .in_instr1_valid (in_instr1_valid),
        .in_ready        (in_ready),
        .out_instr0      (out_instr0),
        .out_instr1      (out_instr1),
        .out_valid0      (out_valid0),
        .out_valid1      (out_valid1),
        .out_ready       (out_ready),
        .split           (split),
`ifdef ISSUE_STATS_EN
        .dual_cnt        (dual_cnt),
        .single_cnt      (single_cnt),
        .split_cnt       (split_cnt),
`endif
        .count           (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hazard-free filler: rd = x0, distinct payload in the upper bits.
    function automatic logic [31:0] d(input int k);
        return 32'h00000013 | (32'(k) << 20);
    endfunction

    task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
        in_valid        = 1'b1;
        in_instr0       = a;
        in_instr1       = b;
        in_instr1_valid = 1'b1;
    endtask

    initial begin
        int idx;
        int np;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr0 = '0;
        in_instr1 = '0; in_instr1_valid = 1'b0; out_ready = 1'b0;
        #1;
        check("rst_count",    32'(count),      32'd0);
        check("rst_in_ready", 32'(in_ready),   32'd1);
        check("rst_valid0",   32'(out_valid0), 32'd0);
        check("rst_valid1",   32'(out_valid1), 32'd0);
        check("rst_split",    32'(split),      32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Independent pair: both issue together
        push_pair(c_ADD_A, c_ADD_B); out_ready = 1'b1;
        check("ind_no_bypass", 32'(out_valid0), 32'd0);
        tick(); in_valid = 1'b0;
        check("ind_count",  32'(count),      32'd2);
        check("ind_valid0", 32'(out_valid0), 32'd1);
        check("ind_valid1", 32'(out_valid1), 32'd1);
        check("ind_split",  32'(split),      32'd0);
        check("ind_instr0", out_instr0,      c_ADD_A);
        check("ind_instr1", out_instr1,      c_ADD_B);
        tick();
        check("ind_drained", 32'(count),     32'd0);

        // RAW pair: split, younger issues next cycle as slot 0
        push_pair(c_ADD_A, c_ADD_RW);
        tick(); in_valid = 1'b0;
        check("raw_valid1", 32'(out_valid1), 32'd0);
        check("raw_split",  32'(split),      32'd1);
        check("raw_instr0", out_instr0,      c_ADD_A);
        tick();
        check("raw_c2_instr0", out_instr0,      c_ADD_RW);
        check("raw_c2_valid0", 32'(out_valid0), 32'd1);
        check("raw_c2_valid1", 32'(out_valid1), 32'd0);
        check("raw_c2_split",  32'(split),      32'd0);
        check("raw_c2_count",  32'(count),      32'd1);
        tick();
        check("raw_drained", 32'(count), 32'd0);

        // Branch in slot 0 always issues alone
        push_pair(c_BEQ, c_ADD_B);
        tick(); in_valid = 1'b0;
        check("br_valid1", 32'(out_valid1), 32'd0);
        check("br_split",  32'(split),      32'd1);
        check("br_instr0", out_instr0,      c_BEQ);
        tick();
        check("br_c2_instr0", out_instr0,      c_ADD_B);
        check("br_c2_valid0", 32'(out_valid0), 32'd1);
        tick();
        check("br_drained", 32'(count), 32'd0);

        // x0 destination never creates a hazard
        push_pair(c_NOP, c_ADD_X0);
        tick(); in_valid = 1'b0;
        check("x0_valid1", 32'(out_valid1), 32'd1);
        check("x0_split",  32'(split),      32'd0);
        tick();
        check("x0_drained", 32'(count), 32'd0);

        // Offset pointers by one so the fill pairs straddle the wrap
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr0 = d(50); in_instr1_valid = 1'b0;
        tick(); in_valid = 1'b0;
        check("single_count", 32'(count), 32'd1);
        check("single_instr", out_instr0, d(50));
        out_ready = 1'b1;
        tick(); out_ready = 1'b0;
        check("single_drained", 32'(count), 32'd0);

        for (int k = 0; k < 4; k++) begin
            push_pair(d(2*k), d(2*k+1));
            tick();
        end
        check("full_count",    32'(count),    32'd8);
        check("full_in_ready", 32'(in_ready), 32'd0);
        push_pair(d(99), d(98));
        tick();
        check("full_ignored", 32'(count), 32'd8);

        // Drain while refilling: order preserved, no loss or duplication
        in_valid = 1'b0; out_ready = 1'b1;
        idx = 0; np = 0;
        for (int cyc = 0; cyc < 40 && !(idx >= 12 && count == 0); cyc++) begin
            if (out_valid0 && idx < 12) begin
                check("wrap_instr0", out_instr0, d(idx));
                if (out_valid1 && idx + 1 < 12) begin
                    check("wrap_instr1", out_instr1, d(idx + 1));
                end
                idx += out_valid1 ? 2 : 1;
            end
            if (np < 2 && in_ready) begin
                push_pair(d(8 + 2*np), d(9 + 2*np));
                np++;
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        in_valid = 1'b0;
        check("wrap_total", 32'(idx),   32'd12);
        check("wrap_empty", 32'(count), 32'd0);

        // Flush beats same-cycle push and pop
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            push_pair(d(20 + 2*k), d(21 + 2*k));
            tick();
        end
        check("pre_flush_count", 32'(count), 32'd6);
        flush = 1'b1; push_pair(d(30), d(31)); out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("flush_count",    32'(count),      32'd0);
        check("flush_valid0",   32'(out_valid0), 32'd0);
        check("flush_in_ready", 32'(in_ready),   32'd1);
        push_pair(d(40), d(41));
        tick();
        check("post_flush_instr0", out_instr0, d(40));
        check("post_flush_instr1", out_instr1, d(41));
        push_pair(d(42), d(43));
        tick(); in_valid = 1'b0;
        check("pre_rst_count", 32'(count), 32'd4);

        // Asynchronous reset mid-cycle
        #2 rst = 1'b1;
        #1;
        check("arst_count",    32'(count),      32'd0);
        check("arst_valid0",   32'(out_valid0), 32'd0);
        check("arst_in_ready", 32'(in_ready),   32'd1);
        #2 rst = 1'b0;
        tick();
        check("arst_hold_count", 32'(count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dual_issue_queue.md
Name: dual_issue_queue

Overview:
Parametrised successor to the current two-wide instruction issuing unit. Buffers fetched instruction pairs in a DEPTH-entry circular queue and issues up to two instructions per cycle in program order. A slot-1 instruction issues only when it has no hazard against slot 0; otherwise it waits at the queue head and issues as slot 0 on the next issue cycle. Sits between I-Cache fetch and decode, with valid/ready handshakes on both sides and a synchronous flush for branch redirect.

Parameters:
DEPTH, 8, queue entries; power of two, >= 4
INSTR_W, 32, instruction width; RV32 field positions are fixed (rd [11:7], rs1 [19:15], rs2 [24:20], opcode [6:0])

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
flush  input  1  synchronous clear of all queued instructions (redirect)
in_valid  input  1  fetch presents a pair
in_instr0  input  INSTR_W  older fetched instruction
in_instr1  input  INSTR_W  younger fetched instruction
in_instr1_valid  input  1  in_instr1 is meaningful; else push 1 entry
in_ready  output  1  queue can accept 2 entries: free >= 2
out_instr0  output  INSTR_W  oldest queued instruction (head)
out_instr1  output  INSTR_W  head+1 entry
out_valid0  output  1  out_instr0 issuable (count >= 1)
out_valid1  output  1  out_instr1 issuable this cycle (pairing rule met)
out_ready  input  1  decode accepts all asserted out_valid slots this cycle
split  output  1  out_valid0 & count >= 2 & ~out_valid1 (hazard-split pair)
count  output  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset: head/tail pointers 0, count 0; in_ready 1; out_valid0/1 0; split 0; out_instr0/1 don't-care (bench ignores them while valid is low). Optional counters reset to 0.
- Push: when in_valid & in_ready, write in_instr0 at tail; write in_instr1 at tail+1 if in_instr1_valid. Tail advances by 1 or 2, modulo DEPTH.
- Pop: when out_ready & out_valid0, pop 1 + out_valid1 entries. Head advances modulo DEPTH.
- Simultaneous push and pop in the same cycle are legal. Next count = count + pushed - popped. in_ready is computed from the current count only, not from the same-cycle pop.
- Latency: an entry pushed in cycle N is visible at out_instr* in cycle N+1. There is no bypass from the input to the outputs.
- Outputs out_instr*, out_valid*, split and in_ready are combinational from queue state.
- Pairing rule: out_valid1 = count >= 2 AND none of the following hold:
  (a) rd0 != 0 and (rd0 == rs1_1 or rd0 == rs2_1) — RAW hazard.
  (b) rd0 != 0 and rd0 == rd1 — WAW hazard.
  (c) opcode0 is 1100011 (branch), 1101111 (jal) or 1100111 (jalr) — control instructions always issue alone.
- Register fields are compared without format decoding. This is conservative: immediate bits in rs positions may cause false splits, which is acceptable.
- Flush: highest priority. Next cycle count = 0, head = tail = 0, and any same-cycle push and pop are discarded.
- Reset mid-operation clears everything immediately, with the same effect as flush.
- Wrap-around: head+1 and tail+1 index modulo DEPTH, so a pair may straddle the last and first entries.
- Full: in_ready = 0 when free < 2, even if only one entry is pushed. Push attempts while in_ready is low are ignored.
- Empty: out_valid0 = out_valid1 = 0.

Optional Feature:
ISSUE_STATS_EN
- Defined: adds 32-bit output counters dual_cnt (cycles with a 2-wide issue), single_cnt (cycles with a 1-wide issue) and split_cnt (issue cycles where split = 1).
  - Counters increment only on issue cycles (out_ready & out_valid0), wrap at 2^32, and are cleared by rst but not by flush.
- Undefined: these ports and their logic are absent; the remaining behaviour is identical.

Test Plan:
- Independent pair: push 0x002081B3 / 0x00208333, out_ready = 1 -> next cycle out_valid0 = out_valid1 = 1, split = 0; both popped; count returns to 0.
- RAW pair: push 0x002081B3 / 0x004182B3 -> cycle 1: out_valid1 = 0, split = 1, pops 1. Cycle 2: out_instr0 = 0x004182B3, out_valid0 = 1, out_valid1 = 0.
- Branch first: push 0x00208463 / 0x00208333 -> the branch issues alone, split = 1. The next cycle issues 0x00208333.
- x0 destination: push 0x00000013 / 0x004002B3 -> out_valid1 = 1 (no hazard through x0).
- Fill and wrap: DEPTH = 8, out_ready = 0, push 4 pairs -> count = 8, in_ready = 0. Release out_ready and push again -> order preserved across the wrap; no loss or duplication.
- Flush with push/pop: count = 6, flush with in_valid = 1 and out_ready = 1 -> next cycle count = 0, out_valid0 = 0. Pulse rst mid-fill -> same empty state asynchronously.
